// File: rtl/spi_wb_pkg.sv
// spi_wb_pkg: shared states and constants for the SPI-to-Wishbone bridge
package spi_wb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_BUS} state_t;
  localparam int CMD_WE_BIT = 7;
  localparam logic [7:0] READ_ERR_DATA = 8'hFF;
endpackage

// File: rtl/spi_wb_sync.sv
// spi_wb_sync: 2-flop synchroniser with rise/fall pulses taken from the synced value
module spi_wb_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] r_s;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_s <= {3{RST_VAL}};
    else r_s <= {r_s[1:0], d_i};
  assign q_o = r_s[1];
  assign rise_o = r_s[1] & ~r_s[2];
  assign fall_o = ~r_s[1] & r_s[2];
endmodule

// File: rtl/spi_wb_bridge.sv
// spi_wb_bridge: SPI mode-0 slave issuing 8-bit Wishbone classic cycles from a command byte
// followed by an auto-incrementing read or write burst.
module spi_wb_bridge
  import spi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sck_i,
  input  logic                  cs_ni,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [7:0]            dat_o,
  input  logic [7:0]            dat_i,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i,
  output logic                  bus_error_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_state_nxt;
  logic w_sck, w_sck_rise, w_sck_fall, w_cs_n, w_cs_rise, w_cs_fall;
  logic [1:0] r_mosi_s;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx, r_tx, r_dat;
  logic [6:0] r_adr;
  logic r_we, r_abort, r_bus_error, r_miso;
  logic [TW-1:0] r_tmo;
  logic [7:0] w_byte;
  logic w_byte_done, w_tmo, w_done, w_fault, w_bus_done;
  spi_wb_sync #(.RST_VAL(1'b0)) u_sck (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sck_i),
    .q_o(w_sck), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
  );
  spi_wb_sync #(.RST_VAL(1'b1)) u_cs (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(cs_ni),
    .q_o(w_cs_n), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );
  assign w_byte = {r_rx[6:0], r_mosi_s[1]};
  assign w_byte_done = w_sck_rise && r_bit_cnt == 3'd7;
  assign w_tmo = r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign w_done = ack_i | err_i | rty_i | w_tmo;
  assign w_fault = err_i | rty_i | (w_tmo & ~ack_i);
  assign w_bus_done = r_state == S_BUS && w_done;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  // a frame only starts with sck idle low, as mode 0 requires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = (!w_cs_n && !w_sck) ? S_CMD : S_IDLE;
      S_CMD:  w_state_nxt = w_cs_rise ? S_IDLE : !w_byte_done ? S_CMD : w_byte[CMD_WE_BIT] ? S_DATA : S_BUS;
      S_DATA: w_state_nxt = w_cs_rise ? S_IDLE : w_byte_done ? S_BUS : S_DATA;
      S_BUS:  w_state_nxt = !w_done ? S_BUS : (r_abort || w_cs_rise) ? S_IDLE : S_DATA;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_mosi_s <= '0;
      r_bit_cnt <= '0;
      r_rx <= '0;
      r_tx <= '0;
      r_dat <= '0;
      r_adr <= '0;
      r_we <= 1'b0;
      r_abort <= 1'b0;
      r_bus_error <= 1'b0;
      r_miso <= 1'b0;
      r_tmo <= '0;
    end else begin
      r_mosi_s <= {r_mosi_s[0], mosi_i};
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
        r_tx <= '0;
        r_miso <= 1'b0;
        r_abort <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_rx <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_sck_fall) r_miso <= r_tx[3'd7 - r_bit_cnt];
        if (r_state == S_BUS && w_cs_rise) r_abort <= 1'b1;
      end
      r_tmo <= (r_state == S_BUS && !w_done) ? r_tmo + TW'(1) : '0;
      if (w_byte_done && !w_cs_rise && r_state == S_CMD) begin
        r_we <= w_byte[CMD_WE_BIT];
        r_adr <= w_byte[6:0];
      end
      // in a read burst each completed byte prefetches the following address
      if (w_byte_done && !w_cs_rise && r_state == S_DATA) begin
        if (r_we) r_dat <= w_byte;
        else r_adr <= r_adr + 7'd1;
      end
      if (w_bus_done && !r_we) r_tx <= w_fault ? READ_ERR_DATA : dat_i;
      if (w_bus_done && r_we && !w_fault) r_adr <= r_adr + 7'd1;
      if (w_cs_fall) r_bus_error <= 1'b0;
      if (w_bus_done && w_fault) r_bus_error <= 1'b1;
    end
  assign cyc_o = r_state == S_BUS;
  assign stb_o = r_state == S_BUS;
  assign we_o = r_we;
  assign adr_o = ADDR_WIDTH'(r_adr);
  assign dat_o = r_dat;
  assign miso_o = r_miso;
  assign bus_error_o = r_bus_error;
endmodule
